// File: rtl/rr_arbitrated_fifo_bank.sv
// Bank of NUM_FIFOS circular FIFOs with a shared push port, drained by a round-robin arbiter into one registered ready/valid output.
// Optional feature macro: PUSH_REDIRECT_EN (redirect a push aimed at a full FIFO to the next FIFO with space).
module rr_arbitrated_fifo_bank #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAGWIDTH  = $clog2(NUM_FIFOS),
  parameter int unsigned CNTWIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [TAGWIDTH-1:0]           push_sel,
  input  logic [WIDTH-1:0]              push_data,
  output logic                          push_ack,
  output logic [TAGWIDTH-1:0]           push_tag,
  input  logic [NUM_FIFOS-1:0]          reqs,
  input  logic                          out_rdy,
  output logic                          out_vld,
  output logic [WIDTH-1:0]              out_data,
  output logic [TAGWIDTH-1:0]           out_tag,
  output logic [NUM_FIFOS-1:0]          gnt,
  output logic [NUM_FIFOS-1:0]          full,
  output logic [NUM_FIFOS-1:0]          empty,
  output logic [NUM_FIFOS*CNTWIDTH-1:0] count
);

  localparam int unsigned PTRW = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem    [NUM_FIFOS][DEPTH];
  logic [PTRW-1:0]     wr_ptr [NUM_FIFOS];
  logic [PTRW-1:0]     rd_ptr [NUM_FIFOS];
  logic [CNTWIDTH-1:0] cnt    [NUM_FIFOS];
  logic [TAGWIDTH-1:0] rr_ptr;

  logic [NUM_FIFOS-1:0] wr_sel;
  logic [NUM_FIFOS-1:0] eligible;
  logic [TAGWIDTH-1:0]  gnt_idx;
  logic [WIDTH-1:0]     head_data;
  logic                 grant_any;
  logic                 sel_ok;
  logic                 sel_full;

  // Per-FIFO status flags and flattened occupancy
  always_comb begin
    full  = '0;
    empty = '0;
    count = '0;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      full[k]  = (cnt[k] == CNTWIDTH'(DEPTH));
      empty[k] = (cnt[k] == '0);
      count[k*CNTWIDTH +: CNTWIDTH] = cnt[k];
    end
  end

  // Push target selection; full is taken from pre-edge occupancy
  always_comb begin
    push_ack = 1'b0;
    push_tag = push_sel;
    wr_sel   = '0;
    sel_ok   = 1'b0;
    sel_full = 1'b0;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      if (push_sel == TAGWIDTH'(k)) begin
        sel_ok   = 1'b1;
        sel_full = full[k];
      end
    end
    if (push && sel_ok) begin
      if (!sel_full) begin
        push_ack = 1'b1;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
          if (push_sel == TAGWIDTH'(k)) wr_sel[k] = 1'b1;
        end
      end
`ifdef PUSH_REDIRECT_EN
      else begin
        for (int unsigned j = 1; j < NUM_FIFOS; j++) begin
          for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
            if (!push_ack && !full[k] && ((32'(push_sel) + j) % NUM_FIFOS) == k) begin
              push_ack  = 1'b1;
              push_tag  = TAGWIDTH'(k);
              wr_sel[k] = 1'b1;
            end
          end
        end
      end
`endif
    end
  end

  // Round-robin grant starting at rr_ptr, only when the output register can take a word
  always_comb begin
    eligible  = reqs & ~empty;
    gnt       = '0;
    gnt_idx   = '0;
    grant_any = 1'b0;
    head_data = '0;
    if (!out_vld || out_rdy) begin
      for (int unsigned j = 0; j < NUM_FIFOS; j++) begin
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
          if (!grant_any && eligible[k] && ((32'(rr_ptr) + j) % NUM_FIFOS) == k) begin
            grant_any = 1'b1;
            gnt[k]    = 1'b1;
            gnt_idx   = TAGWIDTH'(k);
          end
        end
      end
    end
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      if (gnt[k]) head_data = mem[k][rd_ptr[k]];
    end
  end

  // Pointers, occupancy, arbiter pointer and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      rr_ptr   <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
        if (wr_sel[k]) wr_ptr[k] <= (wr_ptr[k] == PTRW'(DEPTH - 1)) ? '0 : wr_ptr[k] + 1'b1;
        if (gnt[k])    rd_ptr[k] <= (rd_ptr[k] == PTRW'(DEPTH - 1)) ? '0 : rd_ptr[k] + 1'b1;
        if (wr_sel[k] && !gnt[k])      cnt[k] <= cnt[k] + 1'b1;
        else if (!wr_sel[k] && gnt[k]) cnt[k] <= cnt[k] - 1'b1;
      end
      if (grant_any) begin
        out_vld  <= 1'b1;
        out_data <= head_data;
        out_tag  <= gnt_idx;
        rr_ptr   <= (gnt_idx == TAGWIDTH'(NUM_FIFOS - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      if (wr_sel[k]) mem[k][wr_ptr[k]] <= push_data;
    end
  end

endmodule

// File: tb/tb_rr_arbitrated_fifo_bank.sv
// Directed self-checking bench for rr_arbitrated_fifo_bank (NUM_FIFOS=4, WIDTH=8, DEPTH=4).
module tb_rr_arbitrated_fifo_bank;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned TW = 2;
  localparam int unsigned CW = 3;
`ifdef PUSH_REDIRECT_EN
  localparam bit REDIR = 1'b1;
`else
  localparam bit REDIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0;
  logic [TW-1:0] push_sel = '0;
  logic [W-1:0]  push_data = '0;
  logic          push_ack;
  logic [TW-1:0] push_tag;
  logic [N-1:0]  reqs = '0;
  logic          out_rdy = 1'b0;
  logic          out_vld;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic [N-1:0]  gnt, full, empty;
  logic [N*CW-1:0] count;

  int checks = 0;
  int errors = 0;

  rr_arbitrated_fifo_bank #(.NUM_FIFOS(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_sel(push_sel), .push_data(push_data),
    .push_ack(push_ack), .push_tag(push_tag), .reqs(reqs), .out_rdy(out_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_tag(out_tag), .gnt(gnt),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic [TW-1:0] sel;
    logic [W-1:0]  data;
    logic [N-1:0]  reqs;
    logic          rdy;
    logic          ack;
    logic [TW-1:0] tag;
    logic [N-1:0]  gnt;
    logic          vld;
    logic [W-1:0]  odata;
    logic [TW-1:0] otag;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int unsigned k);
    return count[k*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic p, input logic [TW-1:0] s, input logic [W-1:0] d);
    push      = p;
    push_sel  = s;
    push_data = d;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0);
    reqs    = '0;
    out_rdy = 1'b1;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd2, 8'hA5, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[1] = '{1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 8'h00, 2'd0};
    vecs[2] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hA5, 2'd2};
    vecs[3] = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 8'hA5, 2'd2};
    vecs[4] = '{1'b1, 2'd1, 8'h22, 4'b0011, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b0, 8'hA5, 2'd2};
    vecs[5] = '{1'b0, 2'd0, 8'h00, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 8'h11, 2'd0};
    vecs[6] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 8'h22, 2'd1};
    vecs[7] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h22, 2'd1};

    // Reset state
    do_reset();
    settle();
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(push_ack), 32'd0);

    // Basic push/grant/output vectors
    for (int i = 0; i < 8; i++) begin
      step();
      drive(vecs[i].push, vecs[i].sel, vecs[i].data);
      reqs    = vecs[i].reqs;
      out_rdy = vecs[i].rdy;
      settle();
      chk($sformatf("row%0d_ack", i), 32'(push_ack), 32'(vecs[i].ack));
      if (vecs[i].ack) chk($sformatf("row%0d_ptag", i), 32'(push_tag), 32'(vecs[i].tag));
      chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("row%0d_vld", i), 32'(out_vld), 32'(vecs[i].vld));
      chk($sformatf("row%0d_data", i), 32'(out_data), 32'(vecs[i].odata));
      chk($sformatf("row%0d_otag", i), 32'(out_tag), 32'(vecs[i].otag));
    end
    chk("basic_empty", 32'(empty), 32'hF);

    // Fairness: 2 words per FIFO, all requesting
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2; n++) begin
        step();
        drive(1'b1, TW'(k), W'(k * 16 + n));
      end
    end
    step();
    drive(1'b0, '0, '0);
    reqs = 4'b1111;
    settle();
    chk("fair_gnt0", 32'(gnt), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      settle();
      chk($sformatf("fair%0d_vld", i), 32'(out_vld), 32'd1);
      chk($sformatf("fair%0d_tag", i), 32'(out_tag), 32'(i % 4));
      chk($sformatf("fair%0d_data", i), 32'(out_data), 32'((i % 4) * 16 + i / 4));
    end
    step();
    settle();
    chk("fair_end_vld", 32'(out_vld), 32'd0);
    chk("fair_end_empty", 32'(empty), 32'hF);

    // Full FIFO: drop or redirect
    reqs = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      drive(1'b1, 2'd1, W'(8'h60 + n));
      settle();
      chk($sformatf("fill%0d_ack", n), 32'(push_ack), 32'd1);
    end
    step();
    drive(1'b0, '0, '0);
    settle();
    chk("full1", 32'(full[1]), 32'd1);
    chk("count1_full", 32'(cnt_of(1)), 32'd4);
    step();
    drive(1'b1, 2'd1, 8'h6F);
    settle();
    chk("fifth_ack", 32'(push_ack), 32'(REDIR));
    if (push_ack) chk("fifth_tag", 32'(push_tag), 32'd2);
    step();
    drive(1'b0, '0, '0);
    settle();
    chk("fifth_count1", 32'(cnt_of(1)), 32'd4);
    chk("fifth_count2", 32'(cnt_of(2)), 32'(REDIR));
    step();
    reqs = 4'b0010;
    settle();
    chk("drain_gnt", 32'(gnt), 32'h2);
    for (int n = 0; n < 4; n++) begin
      step();
      settle();
      chk($sformatf("drain%0d_vld", n), 32'(out_vld), 32'd1);
      chk($sformatf("drain%0d_data", n), 32'(out_data), 32'(8'h60 + n));
      chk($sformatf("drain%0d_tag", n), 32'(out_tag), 32'd1);
    end
    step();
    settle();
    chk("drain_end_vld", 32'(out_vld), 32'd0);
    chk("drain_empty1", 32'(empty[1]), 32'd1);

    // Backpressure
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b1, TW'(k), W'(8'h40 + k));
    end
    step();
    drive(1'b0, '0, '0);
    reqs    = 4'b0111;
    out_rdy = 1'b0;
    settle();
    chk("bp_first_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      chk($sformatf("bp%0d_gnt", i), 32'(gnt), 32'h0);
      chk($sformatf("bp%0d_vld", i), 32'(out_vld), 32'd1);
      chk($sformatf("bp%0d_data", i), 32'(out_data), 32'h40);
      chk($sformatf("bp%0d_tag", i), 32'(out_tag), 32'd0);
      chk($sformatf("bp%0d_cnt1", i), 32'(cnt_of(1)), 32'd1);
      chk($sformatf("bp%0d_cnt2", i), 32'(cnt_of(2)), 32'd1);
    end
    step();
    out_rdy = 1'b1;
    settle();
    chk("bp_resume_gnt", 32'(gnt), 32'h2);
    step();
    settle();
    chk("bp_next_data", 32'(out_data), 32'h41);
    chk("bp_next_tag", 32'(out_tag), 32'd1);
    chk("bp_next_gnt", 32'(gnt), 32'h4);
    step();
    reqs = '0;
    settle();
    chk("bp_last_data", 32'(out_data), 32'h42);
    chk("bp_last_tag", 32'(out_tag), 32'd2);

    // Interleaved push+pop on FIFO 0 with pointer wrap
    for (int i = 0; i < 13; i++) begin
      step();
      drive(i < 10, 2'd0, W'(i + 1));
      reqs = 4'b0001;
      settle();
      chk($sformatf("wrap%0d_cnt", i), 32'(cnt_of(0)), (i >= 1 && i <= 10) ? 32'd1 : 32'd0);
      chk($sformatf("wrap%0d_vld", i), 32'(out_vld), (i >= 2 && i <= 11) ? 32'd1 : 32'd0);
      if (i >= 2 && i <= 11) chk($sformatf("wrap%0d_data", i), 32'(out_data), 32'(i - 1));
    end

    // Asynchronous reset in the middle of a stalled stream
    reqs    = '0;
    out_rdy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      drive(1'b1, 2'd3, W'(8'h70 + n));
    end
    step();
    drive(1'b1, 2'd0, 8'h7A);
    step();
    drive(1'b0, '0, '0);
    reqs = 4'b0001;
    step();
    reqs = '0;
    settle();
    chk("pre_rst_vld", 32'(out_vld), 32'd1);
    chk("pre_rst_data", 32'(out_data), 32'h7A);
    chk("pre_rst_full3", 32'(full[3]), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_vld), 32'd0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_full", 32'(full), 32'h0);
    chk("arst_empty", 32'(empty), 32'hF);
    step();
    rst_n   = 1'b1;
    reqs    = 4'b1111;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("post_rst%0d_gnt", i), 32'(gnt), 32'h0);
      chk($sformatf("post_rst%0d_vld", i), 32'(out_vld), 32'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
